// File: rtl/ctrl_flow_buffer.sv
// Control-flow side buffer indexed by ROB entry: dispatch snapshot, write-back
// resolution, and in-order presentation of resolved entries at commit.
module ctrl_flow_buffer #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned CTRL_W = 14,
  parameter int unsigned DEPTH  = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  output logic [PTR_W-1:0]  alloc_idx,
  input  logic [WIDTH-1:0]  alloc_seq_pc,
  input  logic [WIDTH-1:0]  alloc_reg_status,
  input  logic              wb_valid,
  input  logic [PTR_W-1:0]  wb_entry,
  input  logic [WIDTH-1:0]  wb_target,
  input  logic [CTRL_W-1:0] wb_ctrl,
  output logic              commit_valid,
  input  logic              commit_ready,
  output logic [PTR_W-1:0]  commit_idx,
  output logic [WIDTH-1:0]  commit_seq_pc,
  output logic [WIDTH-1:0]  commit_reg_status,
  output logic [WIDTH-1:0]  commit_target,
  output logic [CTRL_W-1:0] commit_ctrl,
  output logic              commit_redirect,
  input  logic              flush,
  output logic [PTR_W:0]    count
);

  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  logic [PTR_W:0]    head_q, head_d;
  logic [PTR_W:0]    tail_q, tail_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [DEPTH-1:0]  alloc_v_q, alloc_v_d;
  logic [DEPTH-1:0]  done_q, done_d;

  logic [WIDTH-1:0]  seq_pc_mem     [DEPTH];
  logic [WIDTH-1:0]  reg_status_mem [DEPTH];
  logic [WIDTH-1:0]  target_mem     [DEPTH];
  logic [CTRL_W-1:0] ctrl_mem       [DEPTH];

  logic [PTR_W-1:0]  head_idx;
  logic [PTR_W-1:0]  tail_idx;
  logic              empty;
  logic              full;
  logic              alloc_fire;
  logic              commit_fire;
  logic              wb_accept;

  assign head_idx = head_q[PTR_W-1:0];
  assign tail_idx = tail_q[PTR_W-1:0];
  assign empty    = (head_q == tail_q);
  assign full     = (head_idx == tail_idx) && (head_q[PTR_W] != tail_q[PTR_W]);

  // Ready comes only from registered pointers; a same-cycle commit never frees a slot early.
  assign alloc_ready  = ~full;
  assign alloc_idx    = tail_idx;
  assign commit_valid = ~empty & done_q[head_idx];
  assign commit_idx   = head_idx;
  assign count        = count_q;

  assign alloc_fire  = alloc_valid & ~full & ~flush;
  assign commit_fire = commit_valid & commit_ready & ~flush;
  // An entry being allocated this cycle still reads alloc_v=0, so a colliding write-back is dropped.
  assign wb_accept   = wb_valid & alloc_v_q[wb_entry] & ~flush;

  always_comb begin
    commit_seq_pc     = '0;
    commit_reg_status = '0;
    commit_target     = '0;
    commit_ctrl       = '0;
    if (commit_valid) begin
      commit_seq_pc     = seq_pc_mem[head_idx];
      commit_reg_status = reg_status_mem[head_idx];
      commit_target     = target_mem[head_idx];
      commit_ctrl       = ctrl_mem[head_idx];
    end
    commit_redirect = commit_valid & (commit_ctrl[1] | commit_ctrl[0]);
  end

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    alloc_v_d = alloc_v_q;
    done_d    = done_q;
    if (flush) begin
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
      alloc_v_d = '0;
      done_d    = '0;
    end else begin
      if (wb_accept) begin
        done_d[wb_entry] = 1'b1;
      end
      if (commit_fire) begin
        alloc_v_d[head_idx] = 1'b0;
        head_d              = head_q + PTR_ONE;
      end
      if (alloc_fire) begin
        alloc_v_d[tail_idx] = 1'b1;
        done_d[tail_idx]    = 1'b0;
        tail_d              = tail_q + PTR_ONE;
      end
      if (alloc_fire && !commit_fire) begin
        count_d = count_q + PTR_ONE;
      end else if (commit_fire && !alloc_fire) begin
        count_d = count_q - PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      alloc_v_q <= '0;
      done_q    <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      alloc_v_q <= alloc_v_d;
      done_q    <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      seq_pc_mem[tail_idx]     <= alloc_seq_pc;
      reg_status_mem[tail_idx] <= alloc_reg_status;
    end
    if (wb_accept) begin
      target_mem[wb_entry] <= wb_target;
      ctrl_mem[wb_entry]   <= wb_ctrl;
    end
  end

endmodule

// File: tb/tb_ctrl_flow_buffer.sv
// Bench for ctrl_flow_buffer: directed scenarios plus random traffic, all checked
// against a window-based reference model (head + occupancy) every cycle.
module tb_ctrl_flow_buffer;

  localparam int WIDTH  = 32;
  localparam int CTRL_W = 14;
  localparam int DEPTH  = 8;
  localparam int PTR_W  = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              alloc_valid;
  logic              alloc_ready;
  logic [PTR_W-1:0]  alloc_idx;
  logic [WIDTH-1:0]  alloc_seq_pc;
  logic [WIDTH-1:0]  alloc_reg_status;
  logic              wb_valid;
  logic [PTR_W-1:0]  wb_entry;
  logic [WIDTH-1:0]  wb_target;
  logic [CTRL_W-1:0] wb_ctrl;
  logic              commit_valid;
  logic              commit_ready;
  logic [PTR_W-1:0]  commit_idx;
  logic [WIDTH-1:0]  commit_seq_pc;
  logic [WIDTH-1:0]  commit_reg_status;
  logic [WIDTH-1:0]  commit_target;
  logic [CTRL_W-1:0] commit_ctrl;
  logic              commit_redirect;
  logic              flush;
  logic [PTR_W:0]    count;

  always #5 clk = ~clk;

  ctrl_flow_buffer #(.WIDTH(WIDTH), .CTRL_W(CTRL_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
    .alloc_seq_pc(alloc_seq_pc), .alloc_reg_status(alloc_reg_status),
    .wb_valid(wb_valid), .wb_entry(wb_entry), .wb_target(wb_target), .wb_ctrl(wb_ctrl),
    .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_idx(commit_idx),
    .commit_seq_pc(commit_seq_pc), .commit_reg_status(commit_reg_status),
    .commit_target(commit_target), .commit_ctrl(commit_ctrl),
    .commit_redirect(commit_redirect), .flush(flush), .count(count)
  );

  // Reference model: in-flight entries are the window [m_head, m_head+m_cnt) mod DEPTH.
  int               m_head;
  int               m_cnt;
  bit               m_done [DEPTH];
  logic [WIDTH-1:0] m_pc   [DEPTH];
  logic [WIDTH-1:0] m_rs   [DEPTH];
  logic [WIDTH-1:0] m_tgt  [DEPTH];
  logic [CTRL_W-1:0] m_ctrl [DEPTH];

  int n_checks = 0;
  int n_pass   = 0;
  int c_idx [$];
  logic [WIDTH-1:0] c_pc [$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic bit m_in_window(input int e);
    return ((e - m_head + DEPTH) % DEPTH) < m_cnt;
  endfunction

  task automatic model_reset();
    m_head = 0;
    m_cnt  = 0;
    for (int i = 0; i < DEPTH; i++) m_done[i] = 1'b0;
  endtask

  task automatic model_step();
    bit cfire;
    bit afire;
    int tl;
    if (flush) begin
      model_reset();
    end else begin
      cfire = commit_ready && m_cnt > 0 && m_done[m_head];
      afire = alloc_valid && m_cnt < DEPTH;
      tl    = (m_head + m_cnt) % DEPTH;
      if (wb_valid && m_in_window(int'(wb_entry))) begin
        m_tgt[wb_entry]  = wb_target;
        m_ctrl[wb_entry] = wb_ctrl;
        m_done[wb_entry] = 1'b1;
      end
      if (afire) begin
        m_pc[tl]   = alloc_seq_pc;
        m_rs[tl]   = alloc_reg_status;
        m_done[tl] = 1'b0;
      end
      if (cfire) m_head = (m_head + 1) % DEPTH;
      m_cnt = m_cnt + int'(afire) - int'(cfire);
    end
  endtask

  task automatic compare_model();
    bit cv;
    cv = m_cnt > 0 && m_done[m_head];
    chk("alloc_ready", alloc_ready, m_cnt < DEPTH);
    chk("alloc_idx", alloc_idx, (m_head + m_cnt) % DEPTH);
    chk("count", count, m_cnt);
    chk("commit_valid", commit_valid, cv);
    if (cv) chk("commit_idx", commit_idx, m_head);
    chk("commit_seq_pc", commit_seq_pc, cv ? m_pc[m_head] : '0);
    chk("commit_reg_status", commit_reg_status, cv ? m_rs[m_head] : '0);
    chk("commit_target", commit_target, cv ? m_tgt[m_head] : '0);
    chk("commit_ctrl", commit_ctrl, cv ? m_ctrl[m_head] : '0);
    chk("commit_redirect", commit_redirect, cv && (m_ctrl[m_head][1] || m_ctrl[m_head][0]));
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic cycle();
    #1;
    compare_model();
    if (commit_valid && commit_ready && !flush) begin
      c_idx.push_back(int'(commit_idx));
      c_pc.push_back(commit_seq_pc);
    end
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    alloc_valid      = 1'b0;
    alloc_seq_pc     = '0;
    alloc_reg_status = '0;
    wb_valid         = 1'b0;
    wb_entry         = '0;
    wb_target        = '0;
    wb_ctrl          = '0;
    commit_ready     = 1'b0;
    flush            = 1'b0;
  endtask

  task automatic do_flush();
    idle();
    flush = 1'b1;
    cycle();
    idle();
  endtask

  initial begin
    reset = 1'b0;
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    chk("reset_count", count, 0);
    chk("reset_alloc_ready", alloc_ready, 1);

    // Mid-stream asynchronous reset with 3 entries, head resolved.
    for (int k = 0; k < 3; k++) begin
      idle();
      alloc_valid = 1'b1; alloc_seq_pc = 32'h40 + 32'(k); alloc_reg_status = 32'hA0 + 32'(k);
      if (k == 2) begin wb_valid = 1'b1; wb_entry = '0; wb_target = 32'h55; wb_ctrl = 14'h3; end
      cycle();
    end
    idle();
    chk("pre_reset_commit_valid", commit_valid, 1);
    chk("pre_reset_count", count, 3);
    #2 reset = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_alloc_ready", alloc_ready, 1);
    chk("arst_alloc_idx", alloc_idx, 0);
    chk("arst_commit_valid", commit_valid, 0);
    chk("arst_commit_redirect", commit_redirect, 0);
    chk("arst_commit_data", {commit_seq_pc, commit_target}, 64'h0);
    chk("arst_commit_ctrl", commit_ctrl, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;

    // Fill with no write-back, then a refused 9th alloc.
    for (int k = 0; k < DEPTH; k++) begin
      idle(); alloc_valid = 1'b1; alloc_seq_pc = 32'h300 + 32'(k); cycle();
    end
    chk("full_count", count, 8);
    chk("full_alloc_ready", alloc_ready, 0);
    chk("full_alloc_idx", alloc_idx, 0);
    idle(); alloc_valid = 1'b1; alloc_seq_pc = 32'hDEAD; cycle();
    chk("ninth_count", count, 8);
    chk("ninth_alloc_idx", alloc_idx, 0);

    // Full buffer, head resolved, alloc and commit together: commit only.
    idle(); wb_valid = 1'b1; wb_entry = '0; wb_target = 32'h77; cycle();
    idle(); alloc_valid = 1'b1; alloc_seq_pc = 32'hBEEF; commit_ready = 1'b1; cycle();
    chk("fullcommit_count", count, 7);
    chk("fullcommit_alloc_idx", alloc_idx, 0);
    chk("fullcommit_alloc_ready", alloc_ready, 1);
    do_flush();

    // Out-of-order resolution, in-order commit.
    c_idx.delete(); c_pc.delete();
    for (int k = 0; k < 3; k++) begin
      idle(); commit_ready = 1'b1; alloc_valid = 1'b1; alloc_seq_pc = 32'h200 + 32'(k); cycle();
    end
    idle(); commit_ready = 1'b1; wb_valid = 1'b1; wb_entry = 3'd2; wb_target = 32'h1002; cycle();
    chk("ooo_valid_after_wb2", commit_valid, 0);
    idle(); commit_ready = 1'b1; wb_valid = 1'b1; wb_entry = 3'd0; wb_target = 32'h1000; cycle();
    chk("ooo_valid_after_wb0", commit_valid, 1);
    chk("ooo_idx_after_wb0", commit_idx, 0);
    idle(); commit_ready = 1'b1; cycle();
    chk("ooo_blocked", commit_valid, 0);
    chk("ooo_count_2", count, 2);
    cycle();
    chk("ooo_still_blocked", commit_valid, 0);
    wb_valid = 1'b1; wb_entry = 3'd1; wb_target = 32'h1001; cycle();
    wb_valid = 1'b0;
    chk("ooo_idx1", commit_idx, 1);
    cycle();
    chk("ooo_idx2", commit_idx, 2);
    cycle();
    chk("ooo_count_0", count, 0);
    chk("ooo_ncommits", c_idx.size(), 3);
    for (int k = 0; k < 3 && k < c_idx.size(); k++) chk("ooo_order", c_idx[k], k);
    do_flush();

    // Streaming 12 instructions through a wrapping tail.
    c_idx.delete(); c_pc.delete();
    for (int i = 0; i < 15; i++) begin
      idle();
      commit_ready = 1'b1;
      if (i < 12) begin
        chk("stream_alloc_idx", alloc_idx, i % 8);
        alloc_valid = 1'b1; alloc_seq_pc = 32'h100 + 32'(4 * i); alloc_reg_status = 32'(i);
      end
      if (i >= 1 && i <= 12) begin
        wb_valid = 1'b1; wb_entry = PTR_W'((i - 1) % 8); wb_target = 32'h8000 + 32'(i);
      end
      cycle();
    end
    chk("stream_ncommits", c_pc.size(), 12);
    for (int k = 0; k < 12 && k < c_pc.size(); k++) chk("stream_pc", c_pc[k], 32'h100 + 32'(4 * k));
    do_flush();

    // Flush beats simultaneous alloc and write-back; stale write-back dropped.
    for (int k = 0; k < 5; k++) begin
      idle(); alloc_valid = 1'b1; alloc_seq_pc = 32'h500 + 32'(k);
      if (k > 0) begin wb_valid = 1'b1; wb_entry = PTR_W'(k - 1); wb_target = 32'h600 + 32'(k); end
      cycle();
    end
    idle(); flush = 1'b1; alloc_valid = 1'b1; alloc_seq_pc = 32'h999;
    wb_valid = 1'b1; wb_entry = 3'd4; commit_ready = 1'b1; cycle();
    chk("flush_count", count, 0);
    chk("flush_alloc_idx", alloc_idx, 0);
    chk("flush_commit_valid", commit_valid, 0);
    idle(); wb_valid = 1'b1; wb_entry = 3'd3; wb_target = 32'hBAD; cycle();
    chk("dropped_wb_count", count, 0);
    chk("dropped_wb_valid", commit_valid, 0);
    idle(); alloc_valid = 1'b1; alloc_seq_pc = 32'h700; cycle();
    chk("post_flush_count", count, 1);
    chk("post_flush_valid", commit_valid, 0);
    do_flush();

    // Redirect flag from mispredict bit.
    idle(); alloc_valid = 1'b1; alloc_seq_pc = 32'h900; cycle();
    idle(); wb_valid = 1'b1; wb_entry = 3'd0; wb_target = 32'h1234; wb_ctrl = 14'h0002; cycle();
    idle();
    chk("redir_valid", commit_valid, 1);
    chk("redir_flag", commit_redirect, 1);
    chk("redir_ctrl", commit_ctrl, 14'h0002);
    chk("redir_target", commit_target, 32'h1234);
    commit_ready = 1'b1; alloc_valid = 1'b1; alloc_seq_pc = 32'h904; cycle();
    idle(); wb_valid = 1'b1; wb_entry = 3'd1; wb_ctrl = 14'h0; cycle();
    idle();
    chk("noredir_valid", commit_valid, 1);
    chk("noredir_flag", commit_redirect, 0);
    do_flush();

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      idle();
      alloc_valid      = ($urandom_range(0, 9) < 6);
      alloc_seq_pc     = $urandom;
      alloc_reg_status = $urandom;
      wb_valid         = ($urandom_range(0, 1) == 1);
      if (m_cnt > 0 && $urandom_range(0, 3) != 0)
        wb_entry = PTR_W'((m_head + int'($urandom_range(0, m_cnt - 1))) % DEPTH);
      else
        wb_entry = PTR_W'($urandom_range(0, DEPTH - 1));
      wb_target    = $urandom;
      wb_ctrl      = CTRL_W'($urandom);
      commit_ready = ($urandom_range(0, 9) < 7);
      flush        = ($urandom_range(0, 49) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
